// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL lock/enable inputs and power/status outputs of the lock sequencer.
interface pll_lock_sequencer_if;
  logic       PLL_LOCK;
  logic       ENABLE;
  logic       POWERDOWN_N;
  logic       OUTx_EN;
  logic       READY;
  logic       FAULT;
  logic [2:0] RETRY_CNT;
  logic [2:0] STATE;
  modport master (
    output PLL_LOCK, ENABLE,
    input  POWERDOWN_N, OUTx_EN, READY, FAULT, RETRY_CNT, STATE
  );
  modport slave (
    input  PLL_LOCK, ENABLE,
    output POWERDOWN_N, OUTx_EN, READY, FAULT, RETRY_CNT, STATE
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: powers up a PLL, waits for lock, enables its outputs and retries on timeout.
// Optional lock debounce filter is built when PLL_SEQ_LOCK_DEBOUNCE_EN is defined.
module pll_lock_sequencer #(
  parameter int PWRUP_CYCLES    = 256,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int EN_WAIT_CYCLES  = 32000,
  parameter int DIS_WAIT_CYCLES = 32000,
  parameter int MAX_RETRIES     = 3,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input logic                    FREF,
  input logic                    RESET_N,
  pll_lock_sequencer_if.slave    pll
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PWRUP, S_LOCKWAIT, S_ENWAIT, S_RUN, S_DISWAIT, S_PDRETRY, S_FAIL
  } state_e;
  // Zero-length phases are treated as one cycle so every phase has a reachable end count.
  localparam logic [15:0] PW_END  = 16'((PWRUP_CYCLES    < 1 ? 1 : PWRUP_CYCLES)    - 1);
  localparam logic [15:0] LT_END  = 16'((LOCK_TIMEOUT    < 1 ? 1 : LOCK_TIMEOUT)    - 1);
  localparam logic [15:0] EN_END  = 16'((EN_WAIT_CYCLES  < 1 ? 1 : EN_WAIT_CYCLES)  - 1);
  localparam logic [15:0] DIS_END = 16'((DIS_WAIT_CYCLES < 1 ? 1 : DIS_WAIT_CYCLES) - 1);
  localparam logic [2:0]  MAX_R   = 3'(MAX_RETRIES);
  if (MAX_RETRIES < 0 || MAX_RETRIES > 7) begin : g_bad_retries
    $error("MAX_RETRIES must be in 0..7");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic [2:0]  retry_q, retry_d;
  logic        lock_m_q, lock_s_q, lock_f;
  logic        pd_q, oe_q, rdy_q, flt_q;
`ifdef PLL_SEQ_LOCK_DEBOUNCE_EN
  localparam logic [7:0] DB_END = 8'(DEBOUNCE_CYCLES - 1);
  logic [7:0] db_q;
  always_ff @(posedge FREF or negedge RESET_N)
    if (!RESET_N) db_q <= '0;
    else db_q <= !lock_s_q ? 8'd0 : (db_q == DB_END ? db_q : db_q + 8'd1);
  // Rises once lock_s has been high DEBOUNCE_CYCLES cycles, drops with lock_s.
  assign lock_f = lock_s_q && (db_q == DB_END);
`else
  assign lock_f = lock_s_q;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = pll.ENABLE ? S_PWRUP : S_IDLE;
      S_PWRUP:    state_d = !pll.ENABLE ? S_IDLE : (cnt_q == PW_END ? S_LOCKWAIT : S_PWRUP);
      S_LOCKWAIT: state_d = !pll.ENABLE ? S_IDLE : lock_f ? S_ENWAIT :
                            cnt_q != LT_END ? S_LOCKWAIT :
                            (retry_q < MAX_R ? S_PDRETRY : S_FAIL);
      S_ENWAIT:   state_d = (!pll.ENABLE || !lock_f) ? S_DISWAIT :
                            (cnt_q == EN_END ? S_RUN : S_ENWAIT);
      S_RUN:      state_d = (!pll.ENABLE || !lock_f) ? S_DISWAIT : S_RUN;
      S_DISWAIT:  state_d = cnt_q != DIS_END ? S_DISWAIT : (pll.ENABLE ? S_LOCKWAIT : S_IDLE);
      S_PDRETRY:  state_d = !pll.ENABLE ? S_IDLE : (cnt_q == PW_END ? S_PWRUP : S_PDRETRY);
      default:    state_d = pll.ENABLE ? S_FAIL : S_IDLE;
    endcase
    retry_d = (state_d == S_IDLE || state_d == S_RUN) ? 3'd0 :
              (state_q == S_LOCKWAIT && state_d == S_PDRETRY) ? retry_q + 3'd1 : retry_q;
  end
  // Outputs are decoded from the next state so they switch on the same edge as STATE.
  always_ff @(posedge FREF or negedge RESET_N)
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
      pd_q     <= 1'b0;
      oe_q     <= 1'b0;
      rdy_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      retry_q  <= retry_d;
      lock_m_q <= pll.PLL_LOCK;
      lock_s_q <= lock_m_q;
      pd_q     <= state_d inside {S_PWRUP, S_LOCKWAIT, S_ENWAIT, S_RUN, S_DISWAIT};
      oe_q     <= state_d inside {S_ENWAIT, S_RUN};
      rdy_q    <= state_d == S_RUN;
      flt_q    <= state_d == S_FAIL;
    end
  assign pll.POWERDOWN_N = pd_q;
  assign pll.OUTx_EN     = oe_q;
  assign pll.READY       = rdy_q;
  assign pll.FAULT       = flt_q;
  assign pll.RETRY_CNT   = retry_q;
  assign pll.STATE       = state_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bring-up, retry, lock-loss, debounce and reset scenarios
// against a phase/countdown model of the sequencer.
module tb_pll_lock_sequencer;
  localparam int PW = 4, LT = 20, EW = 8, DW = 8, MR = 2, DB = 3;
`ifdef PLL_SEQ_LOCK_DEBOUNCE_EN
  localparam int DBX = DB;
`else
  localparam int DBX = 1;
`endif
  logic FREF = 1'b0;
  logic RESET_N = 1'b0;
  int checks = 0;
  int errors = 0;
  pll_lock_sequencer_if pll();
  pll_lock_sequencer #(
    .PWRUP_CYCLES(PW), .LOCK_TIMEOUT(LT), .EN_WAIT_CYCLES(EW),
    .DIS_WAIT_CYCLES(DW), .MAX_RETRIES(MR), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .FREF(FREF), .RESET_N(RESET_N), .pll(pll)
  );
  always #5 FREF = ~FREF;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: phase number, cycles left in phase, retries, and length of the current lock_s run.
  int   m_st = 0, m_left = 0, m_retry = 0, m_run = 0;
  logic m_l1 = 1'b0, m_ls = 1'b0, m_lf, m_en;
  task automatic enter(input int s, input int n);
    m_st = s;
    m_left = n;
    if (s == 0 || s == 4) m_retry = 0;
  endtask
  always @(posedge FREF or negedge RESET_N) begin
    if (!RESET_N) begin
      m_st = 0; m_left = 0; m_retry = 0; m_run = 0; m_l1 = 1'b0; m_ls = 1'b0;
    end else begin
      m_lf = m_run >= DBX;
      m_en = pll.ENABLE;
      case (m_st)
        0: if (m_en) enter(1, PW);
        1: if (!m_en) enter(0, 0); else if (m_left == 1) enter(2, LT); else m_left--;
        2: if (!m_en) enter(0, 0);
           else if (m_lf) enter(3, EW);
           else if (m_left == 1) begin
             if (m_retry < MR) begin m_retry++; enter(6, PW); end
             else enter(7, 0);
           end else m_left--;
        3: if (!m_en || !m_lf) enter(5, DW); else if (m_left == 1) enter(4, 0); else m_left--;
        4: if (!m_en || !m_lf) enter(5, DW);
        5: if (m_left == 1) enter(m_en ? 2 : 0, m_en ? LT : 0); else m_left--;
        6: if (!m_en) enter(0, 0); else if (m_left == 1) enter(1, PW); else m_left--;
        default: if (!m_en) enter(0, 0);
      endcase
      m_ls = m_l1;
      m_l1 = pll.PLL_LOCK;
      m_run = m_ls ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
    end
  end
  always @(negedge FREF) begin
    chk("model_POWERDOWN_N", pll.POWERDOWN_N, m_st >= 1 && m_st <= 5);
    chk("model_OUTx_EN", pll.OUTx_EN, m_st == 3 || m_st == 4);
    chk("model_READY", pll.READY, m_st == 4);
    chk("model_FAULT", pll.FAULT, m_st == 7);
    chk("model_RETRY_CNT", pll.RETRY_CNT, m_retry);
    chk("model_STATE", pll.STATE, m_st);
  end
  function automatic logic [2:0] probe(input int sel);
    case (sel)
      0: return {2'b00, pll.POWERDOWN_N};
      1: return {2'b00, pll.OUTx_EN};
      2: return {2'b00, pll.READY};
      3: return {2'b00, pll.FAULT};
      4: return pll.RETRY_CNT;
      default: return pll.STATE;
    endcase
  endfunction
  // Counts falling edges until the selected output reaches val; a missed bound reads as 200.
  task automatic measure(input string nm, input int sel, input logic [2:0] val, input int exp);
    int n = 0;
    do begin
      @(negedge FREF);
      n++;
    end while (probe(sel) !== val && n < 200);
    chk(nm, n, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    pll.ENABLE = 1'b0;
    pll.PLL_LOCK = 1'b0;
    repeat (3) @(negedge FREF);
    chk("reset_state", pll.STATE, 0);
    chk("reset_pd", pll.POWERDOWN_N, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge FREF);
    chk("idle_hold", pll.STATE, 0);
    pll.ENABLE = 1'b1;
    measure("pd_rise", 0, 3'd1, 1);
    repeat (9) @(negedge FREF);
    pll.PLL_LOCK = 1'b1;
    measure("oe_rise", 1, 3'd1, DBX + 2);
    measure("ready_rise", 2, 3'd1, 8);
    chk("run_state", pll.STATE, 4);
    chk("run_retry", pll.RETRY_CNT, 0);
    pll.PLL_LOCK = 1'b0;
    @(negedge FREF);
    pll.PLL_LOCK = 1'b1;
    @(negedge FREF);
    chk("oe_hold", pll.OUTx_EN, 1);
    @(negedge FREF);
    chk("oe_fall", pll.OUTx_EN, 0);
    chk("ready_fall", pll.READY, 0);
    chk("diswait_state", pll.STATE, 5);
    measure("diswait_len", 5, 3'd2, 8);
    measure("relock_run", 2, 3'd1, 9);
    pll.ENABLE = 1'b0;
    pll.PLL_LOCK = 1'b0;
    measure("to_idle", 5, 3'd0, 9);
    pll.ENABLE = 1'b1;
    measure("nolock_pd_on", 0, 3'd1, 1);
    measure("retry1_pd_fall", 0, 3'd0, 24);
    chk("retry1_state", pll.STATE, 6);
    chk("retry1_cnt", pll.RETRY_CNT, 1);
    measure("retry1_len", 0, 3'd1, 4);
    measure("retry2_pd_fall", 0, 3'd0, 24);
    chk("retry2_cnt", pll.RETRY_CNT, 2);
    measure("retry2_len", 0, 3'd1, 4);
    measure("fail_entry", 3, 3'd1, 24);
    chk("fail_state", pll.STATE, 7);
    chk("fail_retry", pll.RETRY_CNT, 2);
    chk("fail_pd", pll.POWERDOWN_N, 0);
    repeat (10) @(negedge FREF);
    chk("fault_sticky", pll.FAULT, 1);
    pll.ENABLE = 1'b0;
    measure("fail_exit", 3, 3'd0, 1);
    chk("fail_exit_state", pll.STATE, 0);
    chk("fail_exit_retry", pll.RETRY_CNT, 0);
    pll.ENABLE = 1'b1;
    measure("lockwait_entry", 5, 3'd2, 5);
`ifdef PLL_SEQ_LOCK_DEBOUNCE_EN
    pll.PLL_LOCK = 1'b1;
    repeat (2) @(negedge FREF);
    pll.PLL_LOCK = 1'b0;
    repeat (6) @(negedge FREF);
    chk("glitch_ignored", pll.STATE, 2);
    pll.PLL_LOCK = 1'b1;
    measure("debounced_lock", 5, 3'd3, 5);
`else
    pll.PLL_LOCK = 1'b1;
    measure("direct_lock", 5, 3'd3, 3);
`endif
    measure("run_again", 2, 3'd1, 8);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_pd", pll.POWERDOWN_N, 0);
    chk("async_oe", pll.OUTx_EN, 0);
    chk("async_ready", pll.READY, 0);
    chk("async_fault", pll.FAULT, 0);
    chk("async_retry", pll.RETRY_CNT, 0);
    chk("async_state", pll.STATE, 0);
    @(negedge FREF);
    RESET_N = 1'b1;
    measure("rst_pd_rise", 0, 3'd1, 1);
    measure("rst_oe_rise", 1, 3'd1, 5);
    measure("rst_ready", 2, 3'd1, 8);
    repeat (3) @(negedge FREF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter PWRUP_CYCLES, default 256: cycles POWERDOWN_N is held in each power phase (high in PWRUP, low in PDRETRY); value 0 behaves as 1.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum LOCKWAIT cycles before a retry; value 0 behaves as 1.
REQ-003 SHALL have parameter EN_WAIT_CYCLES, default 32000: settle cycles after asserting OUTx_EN.
REQ-004 SHALL have parameter DIS_WAIT_CYCLES, default 32000: settle cycles after deasserting OUTx_EN.
REQ-005 SHALL have parameter MAX_RETRIES, default 3, range 0..7: lock-timeout retries before FAIL.
REQ-006 SHALL have parameter DEBOUNCE_CYCLES, default 8, range 1..255; used only under REQ-029.
REQ-007 SHALL have ports: FREF  in  1  sole clock, rising edge.
REQ-008 RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-009 PLL_LOCK  in  1  PLL lock indication, asynchronous to FREF.
REQ-010 ENABLE  in  1  level request to run the PLL.
REQ-011 POWERDOWN_N  out  1  PLL power control; 1 = powered.
REQ-012 OUTx_EN  out  1  PLL output divider enable.
REQ-013 READY  out  1  clock stable and usable.
REQ-014 FAULT  out  1  retries exhausted.
REQ-015 RETRY_CNT  out  3  timeouts taken since last RUN or IDLE.
REQ-016 STATE  out  3  encoding: IDLE=0, PWRUP=1, LOCKWAIT=2, ENWAIT=3, RUN=4, DISWAIT=5, PDRETRY=6, FAIL=7.

Function
REQ-017 SHALL synchronize PLL_LOCK through two FREF flops (lock_s); the filtered lock lock_f equals lock_s unless REQ-029 applies.
REQ-018 All outputs SHALL be registered; each is a function of the state register only, except RETRY_CNT, which is its own register.
REQ-019 All wait phases SHALL use one 16-bit counter, cleared on every state entry; a phase of N cycles exits on the edge at which the counter equals N-1.
REQ-020 IDLE: POWERDOWN_N=0, OUTx_EN=0, READY=0, FAULT=0, RETRY_CNT cleared; ENABLE=1 -> PWRUP.
REQ-021 PWRUP: POWERDOWN_N=1; after PWRUP_CYCLES -> LOCKWAIT; ENABLE=0 -> IDLE.
REQ-022 LOCKWAIT: POWERDOWN_N=1, OUTx_EN=0; transitions by priority: ENABLE=0 -> IDLE; lock_f=1 -> ENWAIT; timeout with RETRY_CNT<MAX_RETRIES -> PDRETRY and RETRY_CNT+1; timeout otherwise -> FAIL.
REQ-023 PDRETRY: POWERDOWN_N=0; after PWRUP_CYCLES -> PWRUP; ENABLE=0 -> IDLE.
REQ-024 ENWAIT: OUTx_EN=1; lock_f=0 or ENABLE=0 -> DISWAIT; after EN_WAIT_CYCLES -> RUN.
REQ-025 RUN: OUTx_EN=1, READY=1, RETRY_CNT cleared on entry; lock_f=0 or ENABLE=0 -> DISWAIT, with READY low on the same edge OUTx_EN falls.
REQ-026 DISWAIT: OUTx_EN=0, POWERDOWN_N=1; after DIS_WAIT_CYCLES -> LOCKWAIT if ENABLE=1, else IDLE; the full wait completes even if ENABLE toggles.
REQ-027 FAIL: POWERDOWN_N=0, FAULT=1; ENABLE=0 -> IDLE; FAIL is otherwise sticky.
REQ-028 RETRY_CNT SHALL never exceed MAX_RETRIES; with MAX_RETRIES=0 the first timeout goes directly to FAIL.

Configuration
REQ-029 With macro PLL_SEQ_LOCK_DEBOUNCE_EN defined, lock_f SHALL rise only after lock_s has been 1 for DEBOUNCE_CYCLES consecutive cycles (8-bit counter) and SHALL fall on the first cycle lock_s=0; when undefined, lock_f=lock_s and no debounce logic is built.

Reset
REQ-030 RESET_N=0 SHALL asynchronously force IDLE: POWERDOWN_N=0, OUTx_EN=0, READY=0, FAULT=0, RETRY_CNT=0, STATE=0, counters and sync flops cleared.
REQ-031 Reset mid-operation SHALL deassert OUTx_EN and POWERDOWN_N immediately without a DISWAIT phase; release is synchronous to FREF.

Verification (PWRUP=4, LOCK_TIMEOUT=20, EN_WAIT=8, DIS_WAIT=8, MAX_RETRIES=2, DEBOUNCE=3)
REQ-032 Normal bring-up: ENABLE=1, PLL_LOCK=1 at cycle 10 -> POWERDOWN_N rises 1 cycle after ENABLE; OUTx_EN rises 3 cycles after PLL_LOCK (+2 with debounce); READY rises 8 cycles after OUTx_EN.
REQ-033 No lock: PLL_LOCK=0 -> two PDRETRY pulses of POWERDOWN_N=0 lasting 4 cycles each, RETRY_CNT 1 then 2, then FAIL with FAULT=1; ENABLE=0 -> IDLE with FAULT=0.
REQ-034 Lock loss in RUN: drop PLL_LOCK for 1 cycle -> OUTx_EN=0 and READY=0 3 cycles later, STATE=5 for 8 cycles, then STATE=2 and back to RUN after relock.
REQ-035 Debounce (macro on): PLL_LOCK glitches high for 2 cycles in LOCKWAIT -> no ENWAIT entry; held high for 3 cycles -> ENWAIT.
REQ-036 RESET_N asserted in RUN -> all outputs 0 within the same cycle, without waiting for a FREF edge; after release with ENABLE=1, the full bring-up sequence repeats.
